sram_cache: RTL and testbench
=============================

# sram_cache

Direct-mapped, write-through, no-write-allocate word cache between the core's memory port and the `sram` controller. It serves read hits from on-chip arrays in two cycles and forwards misses and all writes to the external-SRAM controller as single-cycle `mem_valid` pulses. It is stateful:
- tag/valid/data arrays;
- a request state machine;
- a downstream handshake that waits on the controller's `mem_ready` pulse.

## Interface
- `cache_depth`, default 256: number of one-word lines; power of two, at least 2.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; must be the same reset that drives the `sram` controller.
- `cache_in`  in  `mem_in_type`  upstream request (`mem_valid`, `mem_addr`, `mem_wdata`, `mem_wstrb`).
- `cache_out`  out  `mem_out_type`  upstream response (`mem_rdata`, `mem_error`, `mem_ready`).
- `sram_in`  out  `mem_in_type`  downstream request to the `sram` controller.
- `sram_out`  in  `mem_out_type`  downstream response from the `sram` controller.
- `hit_count`  out  32  read-hit counter (only with `SRAM_CACHE_STATS_EN`).
- `miss_count`  out  32  read-miss counter (only with `SRAM_CACHE_STATS_EN`).

## Operation
Address fields:
- index = `mem_addr[idx+1:2]`, where idx = `$clog2(cache_depth)`.
- tag = `mem_addr[31:idx+2]`.
- `mem_addr[1:0]` is ignored.

A request is a write when `|mem_wstrb`; otherwise it is a read.

States:
- IDLE:
  - If `cache_in.mem_valid`=1: latch addr, wdata and wstrb; present the index to the synchronous tag/data arrays; go to LOOKUP.
  - `mem_valid` seen in any other state is ignored. The requester must hold off until `mem_ready`.
- LOOKUP, read:
  - Hit (valid[index] and tag match): drive `cache_out.mem_rdata` = data[index] and `mem_ready`=1 for one cycle; go to IDLE.
  - Miss: go to ISSUE.
- LOOKUP, write:
  - On hit, merge the bytes selected by wstrb into data[index].
  - On miss, leave the arrays untouched (no allocate).
  - Go to ISSUE.
- ISSUE: drive `sram_in.mem_valid`=1 for exactly one cycle with the latched addr, wdata and wstrb (wstrb=0 for reads); go to WAIT.
- WAIT: hold `sram_in.mem_valid`=0 until `sram_out.mem_ready`=1. In that cycle:
  - Read with `mem_error`=0: write `sram_out.mem_rdata` into data[index], set tag[index], set valid[index].
  - Read with `mem_error`=1: clear valid[index].
  - Register the response into `cache_out` and go to RESP.
- RESP: `cache_out.mem_ready`=1 for one cycle. `mem_rdata` = the registered SRAM data (0 for writes). `mem_error` = the registered SRAM error. Go to IDLE.

General rules:
- `cache_out.mem_ready` is a one-cycle pulse. `mem_rdata` and `mem_error` are only meaningful while `mem_ready`=1 and are 0 otherwise.
- At most one downstream request is outstanding.

## Timing
- Reset values: state=IDLE, all valid bits=0 (cleared in one cycle), `cache_out`=0, `sram_in`=0 (`mem_valid`=0). Counters are 0 when `SRAM_CACHE_STATS_EN` is defined.
- Read hit: `mem_valid` in cycle 0 → `mem_ready` in cycle 2.
- Read miss and any write: `sram_in.mem_valid` in cycle 2. If `sram_out.mem_ready` arrives in cycle N, `cache_out.mem_ready` is in cycle N+1.
- Back-to-back: a new `mem_valid` is accepted in the cycle right after `mem_ready`.
- A read immediately after a write to the same address hits with the merged data, because the array merge completes in LOOKUP.
- Reset asserted mid-operation: return to IDLE next edge and raise no response. An in-flight downstream response is discarded; the controller resets in the same cycle.
- Tag mismatch on a valid line: treat as miss; the line is overwritten on fill.

## Configuration
- `SRAM_CACHE_STATS_EN` defined:
  - `hit_count` increments on each read hit in LOOKUP.
  - `miss_count` increments on each read miss in LOOKUP.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
  - Writes count in neither.
- `SRAM_CACHE_STATS_EN` undefined: the counters and both ports are absent, and the rest of the behaviour is identical.

## Test plan
- After reset, read 0x00000100; the SRAM model returns 0xDEADBEEF → exactly one `sram_in.mem_valid` pulse, wstrb=0; `cache_out.mem_rdata`=0xDEADBEEF one cycle after the SRAM ready.
- Read 0x00000100 again → `mem_ready` 2 cycles after `mem_valid`, rdata=0xDEADBEEF, no downstream request; `hit_count`=1, `miss_count`=1.
- Write 0x000000AA with wstrb=0001 to 0x00000100 → a downstream write is issued; the following read hits with 0xDEADBEAA.
- Read 0x00000100 + 4·`cache_depth` (same index, different tag) → miss and refill. A subsequent read of 0x00000100 misses again.
- SRAM model returns `mem_error`=1 on a read miss → `cache_out.mem_error`=1. A repeat read of that address misses.
- Assert `reset` while in WAIT → no `cache_out.mem_ready`, all outputs 0. A previously cached address misses afterwards.

Source files
------------

// File: rtl/sram_cache.sv
// Direct-mapped, write-through, no-write-allocate one-word-line cache in front of the sram controller.
// Optional read hit/miss counters are enabled by defining SRAM_CACHE_STATS_EN.
package sram_cache_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_error;
        logic        mem_ready;
    } mem_out_type;
endpackage

module sram_cache
    import sram_cache_pkg::*;
#(
    parameter int unsigned cache_depth = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  cache_in,
    output mem_out_type cache_out,
    output mem_in_type  sram_in,
    input  mem_out_type sram_out
`ifdef SRAM_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned IW = $clog2(cache_depth);
    localparam int unsigned TW = 30 - IW;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t state, state_nxt;

    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           wstrb_q;
    logic [IW-1:0]        idx_in;
    logic [IW-1:0]        idx_q;
    logic [TW-1:0]        tag_q;
    logic [TW-1:0]        tag_rd;
    logic [31:0]          data_rd;
    logic [cache_depth-1:0] valid;
    logic [TW-1:0]        tag_arr  [cache_depth];
    logic [31:0]          data_arr [cache_depth];

    logic        is_write;
    logic        hit;
    logic        accept;
    logic [31:0] merged;
    logic        data_we;
    logic [31:0] data_wd;
    logic        fill;
    logic        vclr;
    logic        resp_ld;
    mem_out_type resp_d;

    assign idx_in   = cache_in.mem_addr[IW+1:2];
    assign idx_q    = addr_q[IW+1:2];
    assign tag_q    = addr_q[31:IW+2];
    assign is_write = |wstrb_q;
    assign hit      = valid[idx_q] && (tag_rd == tag_q);
    assign accept   = (state == S_IDLE) && cache_in.mem_valid;

    always_comb begin
        merged = data_rd;
        for (int unsigned b = 0; b < 4; b++) begin
            if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        data_we   = 1'b0;
        data_wd   = merged;
        fill      = 1'b0;
        vclr      = 1'b0;
        resp_ld   = 1'b0;
        resp_d    = '0;
        sram_in   = '0;
        case (state)
            S_IDLE: begin
                if (cache_in.mem_valid) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (is_write) begin
                    data_we   = hit;
                    state_nxt = S_ISSUE;
                end else if (hit) begin
                    resp_ld          = 1'b1;
                    resp_d.mem_rdata = data_rd;
                    resp_d.mem_ready = 1'b1;
                    state_nxt        = S_IDLE;
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sram_in.mem_valid = 1'b1;
                sram_in.mem_addr  = addr_q;
                sram_in.mem_wdata = wdata_q;
                sram_in.mem_wstrb = wstrb_q;
                state_nxt         = S_WAIT;
            end
            S_WAIT: begin
                if (sram_out.mem_ready) begin
                    resp_ld          = 1'b1;
                    resp_d.mem_rdata = is_write ? '0 : sram_out.mem_rdata;
                    resp_d.mem_error = sram_out.mem_error;
                    resp_d.mem_ready = 1'b1;
                    if (!is_write) begin
                        if (sram_out.mem_error) begin
                            vclr = 1'b1;
                        end else begin
                            fill    = 1'b1;
                            data_we = 1'b1;
                            data_wd = sram_out.mem_rdata;
                        end
                    end
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            valid     <= '0;
            cache_out <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state     <= state_nxt;
            cache_out <= resp_ld ? resp_d : '0;
            if (accept) begin
                addr_q  <= cache_in.mem_addr;
                wdata_q <= cache_in.mem_wdata;
                wstrb_q <= cache_in.mem_wstrb;
            end
            if (fill) valid[idx_q] <= 1'b1;
            else if (vclr) valid[idx_q] <= 1'b0;
        end
    end

    // Array storage carries no reset; writes are suppressed while reset is held so an
    // in-flight fill cannot land after the controller has been reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (data_we) data_arr[idx_q] <= data_wd;
            if (fill) tag_arr[idx_q] <= tag_q;
        end
        if (accept) begin
            tag_rd  <= tag_arr[idx_in];
            data_rd <= data_arr[idx_in];
        end
    end

`ifdef SRAM_CACHE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == S_LOOKUP && !is_write) begin
            if (hit) hit_count <= hit_count + 32'd1;
            else miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_cache.sv
// Self-checking bench for sram_cache: directed vector table, reset-in-WAIT sequence and
// randomized traffic checked against a word-level cache/memory reference.
module tb_sram_cache;
    import sram_cache_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    mem_in_type  cache_in;
    mem_out_type cache_out;
    mem_in_type  sram_in;
    mem_out_type sram_out;
`ifdef SRAM_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    sram_cache #(.cache_depth(DEPTH)) dut (
        .clock    (clk),
        .reset    (reset),
        .cache_in (cache_in),
        .cache_out(cache_out),
        .sram_in  (sram_in),
        .sram_out (sram_out)
`ifdef SRAM_CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // SRAM behaviour and bookkeeping
    bit [31:0]  smem [int unsigned];
    bit [31:0]  refmem [int unsigned];
    int         ds_count = 0;
    int         extra = 0;
    int         issue_cyc = 0;
    int         ready_cyc = 0;
    mem_in_type ds_req;
    bit         err_next = 1'b0;
    bit         hold = 1'b0;

    // Reference cache contents: line index -> owning word address / data
    bit [31:0] own  [int unsigned];
    bit [31:0] cdat [int unsigned];
    int        ref_hits = 0;
    int        ref_misses = 0;

    typedef struct {
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [3:0]  wstrb;
        bit        inj_err;
        bit        exp_ds;
        bit [31:0] exp_rdata;
        bit        exp_err;
    } vec_t;

    function automatic bit [31:0] dflt(input int unsigned wa);
        return (wa * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] s);
        bit [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic bit [31:0] smem_rd(input int unsigned wa);
        return smem.exists(wa) ? smem[wa] : dflt(wa);
    endfunction

    function automatic bit [31:0] refmem_rd(input int unsigned wa);
        return refmem.exists(wa) ? refmem[wa] : dflt(wa);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // External SRAM controller: one response pulse 1..4 cycles after each request.
    initial begin
        int        lat;
        bit        aborted;
        bit        e;
        int unsigned wa;
        sram_out = '0;
        forever begin
            @(posedge clk); #1;
            if (sram_in.mem_valid && !reset) begin
                ds_count++;
                issue_cyc = cyc;
                ds_req    = sram_in;
                e         = err_next;
                lat       = hold ? 30 : int'($urandom_range(1, 4));
                aborted   = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk); #1;
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (sram_in.mem_valid) extra++;
                end
                if (!aborted) begin
                    wa = ds_req.mem_addr[31:2];
                    sram_out.mem_ready = 1'b1;
                    if (|ds_req.mem_wstrb) begin
                        smem[wa] = merge(smem_rd(wa), ds_req.mem_wdata, ds_req.mem_wstrb);
                        sram_out.mem_rdata = '0;
                        sram_out.mem_error = 1'b0;
                    end else if (e) begin
                        sram_out.mem_rdata = '0;
                        sram_out.mem_error = 1'b1;
                    end else begin
                        sram_out.mem_rdata = smem_rd(wa);
                        sram_out.mem_error = 1'b0;
                    end
                    ready_cyc = cyc;
                    @(posedge clk); #1;
                    sram_out = '0;
                end
            end
        end
    end

    task automatic do_req(input bit [31:0] a, input bit [31:0] wd, input bit [3:0] s,
                          output bit [31:0] rd, output bit er, output int start,
                          output int resp, output int ds, output bit timeout);
        int d0;
        @(posedge clk); #1;
        chk("idle_out", 64'(cache_out), 64'd0);
        cache_in.mem_valid = 1'b1;
        cache_in.mem_addr  = a;
        cache_in.mem_wdata = wd;
        cache_in.mem_wstrb = s;
        start = cyc;
        d0    = ds_count;
        @(posedge clk); #1;
        cache_in = '0;
        timeout  = 1'b1;
        for (int i = 0; i < 200 && timeout; i++) begin
            if (cache_out.mem_ready) timeout = 1'b0;
            else begin
                @(posedge clk); #1;
            end
        end
        rd   = cache_out.mem_rdata;
        er   = cache_out.mem_error;
        resp = cyc;
        ds   = ds_count - d0;
    endtask

    task automatic run_and_check(input string tag, input bit [31:0] a, input bit [31:0] wd,
                                 input bit [3:0] s, input bit inj, input bit exp_ds,
                                 input bit [31:0] exp_rd, input bit exp_er);
        bit [31:0] rd;
        bit        er, to;
        int        start, resp, ds;
        err_next = inj;
        do_req(a, wd, s, rd, er, start, resp, ds, to);
        err_next = 1'b0;
        if (|s) refmem[a[31:2]] = merge(refmem_rd(a[31:2]), wd, s);
        chk({tag, ".timeout"}, 64'(to), 64'd0);
        chk({tag, ".rdata"}, 64'(rd), 64'(exp_rd));
        chk({tag, ".error"}, 64'(er), 64'(exp_er));
        chk({tag, ".downstream"}, 64'(ds), 64'(exp_ds));
        if (!exp_ds) begin
            chk({tag, ".hit_latency"}, 64'(resp - start), 64'd2);
        end else begin
            chk({tag, ".issue_cycle"}, 64'(issue_cyc - start), 64'd2);
            chk({tag, ".resp_after_ready"}, 64'(resp - ready_cyc), 64'd1);
            chk({tag, ".ds_addr"}, 64'(ds_req.mem_addr[31:2]), 64'(a[31:2]));
            chk({tag, ".ds_wstrb"}, 64'(ds_req.mem_wstrb), 64'(s));
            if (|s) chk({tag, ".ds_wdata"}, 64'(ds_req.mem_wdata), 64'(wd));
        end
    endtask

    // Predict the outcome from cache/memory rules, then run and compare.
    task automatic ref_run(input bit [31:0] a, input bit [31:0] wd, input bit [3:0] s, input bit inj);
        int unsigned wa, idx;
        bit          h;
        bit [31:0]   exp_rd;
        bit          exp_er;
        wa     = a[31:2];
        idx    = wa % DEPTH;
        h      = own.exists(idx) && own[idx] == wa;
        exp_rd = '0;
        exp_er = 1'b0;
        if (|s) begin
            if (h) cdat[idx] = merge(cdat[idx], wd, s);
            run_and_check("rand_write", a, wd, s, 1'b0, 1'b1, 32'd0, 1'b0);
        end else if (h) begin
            ref_hits++;
            run_and_check("rand_read_hit", a, wd, s, 1'b0, 1'b0, cdat[idx], 1'b0);
        end else begin
            ref_misses++;
            if (inj) begin
                exp_er = 1'b1;
                own.delete(idx);
            end else begin
                exp_rd    = refmem_rd(wa);
                own[idx]  = wa;
                cdat[idx] = exp_rd;
            end
            run_and_check("rand_read_miss", a, wd, s, inj, 1'b1, exp_rd, exp_er);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        int   bad;
        bit   seen;
        cache_in = '0;
        smem[32'h40]   = 32'hDEADBEEF; refmem[32'h40] = 32'hDEADBEEF;
        smem[32'h50]   = 32'h12345678; refmem[32'h50] = 32'h12345678;
        smem[32'h80]   = 32'hCAFEF00D; refmem[32'h80] = 32'hCAFEF00D;
        smem[32'hC0]   = 32'h11223344; refmem[32'hC0] = 32'h11223344;

        vecs.push_back('{32'h100, 32'h0,        4'b0000, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{32'h100, 32'h0,        4'b0000, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{32'h100, 32'h000000AA, 4'b0001, 1'b0, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{32'h100, 32'h0,        4'b0000, 1'b0, 1'b0, 32'hDEADBEAA, 1'b0});
        vecs.push_back('{32'h140, 32'h0,        4'b0000, 1'b0, 1'b1, 32'h12345678, 1'b0});
        vecs.push_back('{32'h100, 32'h0,        4'b0000, 1'b0, 1'b1, 32'hDEADBEAA, 1'b0});
        vecs.push_back('{32'h200, 32'h0,        4'b0000, 1'b1, 1'b1, 32'h0,        1'b1});
        vecs.push_back('{32'h200, 32'h0,        4'b0000, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{32'h200, 32'h0,        4'b0000, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{32'h300, 32'hAABBCCDD, 4'b1100, 1'b0, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{32'h300, 32'h0,        4'b0000, 1'b0, 1'b1, 32'hAABB3344, 1'b0});
        vecs.push_back('{32'h303, 32'h0,        4'b0000, 1'b0, 1'b0, 32'hAABB3344, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_cache_out", 64'(cache_out), 64'd0);
        chk("reset_sram_in", 64'(sram_in), 64'd0);
`ifdef SRAM_CACHE_STATS_EN
        chk("reset_hit_count", 64'(hit_count), 64'd0);
        chk("reset_miss_count", 64'(miss_count), 64'd0);
`endif
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                          vecs[i].inj_err, vecs[i].exp_ds, vecs[i].exp_rdata, vecs[i].exp_err);
`ifdef SRAM_CACHE_STATS_EN
            if (i == 1) begin
                chk("vec1_hit_count", 64'(hit_count), 64'd1);
                chk("vec1_miss_count", 64'(miss_count), 64'd1);
            end
`endif
        end

        // Reset while a downstream read is outstanding.
        run_and_check("rst_prefill", 32'h104, 32'h0, 4'b0000, 1'b0, 1'b1, dflt(32'h41), 1'b0);
        run_and_check("rst_prehit", 32'h104, 32'h0, 4'b0000, 1'b0, 1'b0, dflt(32'h41), 1'b0);
        hold = 1'b1;
        @(posedge clk); #1;
        cache_in.mem_valid = 1'b1;
        cache_in.mem_addr  = 32'h208;
        cache_in.mem_wstrb = 4'b0000;
        @(posedge clk); #1;
        cache_in = '0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (sram_in.mem_valid) seen = 1'b1;
        end
        chk("rst_issue_seen", 64'(seen), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            if (i == 1) reset = 1'b0;
            if (cache_out != '0 || sram_in != '0) bad++;
        end
        chk("rst_quiet_outputs", 64'(bad), 64'd0);
        hold = 1'b0;
        own.delete();
        ref_hits = 0;
        ref_misses = 0;
        run_and_check("rst_postmiss", 32'h104, 32'h0, 4'b0000, 1'b0, 1'b1, dflt(32'h41), 1'b0);
        own[1] = 32'h41;
        cdat[1] = dflt(32'h41);
        ref_misses = 1;

        for (int n = 0; n < 300; n++) begin
            bit [31:0] a;
            bit [3:0]  s;
            bit        inj;
            a   = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            s   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            inj = (s == 4'b0000) && ($urandom_range(0, 9) == 0);
            ref_run(a, $urandom, s, inj);
        end

        chk("extra_downstream_pulses", 64'(extra), 64'd0);
`ifdef SRAM_CACHE_STATS_EN
        chk("final_hit_count", 64'(hit_count), 64'(ref_hits));
        chk("final_miss_count", 64'(miss_count), 64'(ref_misses));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
